// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of SIG_IN over a window of
// GATE_CYCLES clocks and reports the total on COUNT with a one-cycle VALID strobe.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned GATE_W      = 26,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             SIG_IN,
    input  logic             START,
    input  logic             CONT,
    output logic [CNT_W-1:0] COUNT,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVF
);

    typedef enum logic [1:0] {
        ST_WARM,
        ST_IDLE,
        ST_GATE
    } state_t;

    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    state_t             state;
    logic [1:0]         warm_cnt;
    logic               s1, s2, s3;
    logic [CNT_W-1:0]   edge_cnt;
    logic [GATE_W-1:0]  gate_cnt;
    logic               ovf_int;

    logic               e;
    logic               edge_full;
    logic               sat;
    logic [CNT_W-1:0]   edge_next;

    // A pulse arriving while the counter is already full is what marks a window as saturated.
    always_comb begin
        e         = s2 & ~s3;
        edge_full = &edge_cnt;
        sat       = e & edge_full;
        edge_next = (e && !edge_full) ? edge_cnt + 1'b1 : edge_cnt;
    end

    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state    <= ST_WARM;
            warm_cnt <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            edge_cnt <= '0;
            gate_cnt <= '0;
            ovf_int  <= 1'b0;
            COUNT    <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b1;
            OVF      <= 1'b0;
        end else begin
            s1    <= SIG_IN;
            s2    <= s1;
            s3    <= s2;
            VALID <= 1'b0;

            case (state)
                ST_WARM: begin
                    if (warm_cnt == 2'd2) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        warm_cnt <= warm_cnt + 2'd1;
                    end
                end

                ST_IDLE: begin
                    if (START || CONT) begin
                        edge_cnt <= '0;
                        gate_cnt <= GATE_LOAD;
                        ovf_int  <= 1'b0;
                        state    <= ST_GATE;
                        BUSY     <= 1'b1;
                    end
                end

                ST_GATE: begin
                    if (gate_cnt == '0) begin
                        // Final cycle: the edge seen now still belongs to this window.
                        COUNT <= edge_next;
                        OVF   <= ovf_int | sat;
                        VALID <= 1'b1;
                        if (CONT) begin
                            edge_cnt <= '0;
                            gate_cnt <= GATE_LOAD;
                            ovf_int  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        edge_cnt <= edge_next;
                        ovf_int  <= ovf_int | sat;
                        gate_cnt <= gate_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= ST_WARM;
                    BUSY  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle window and a 4-bit counter.
module tb_freq_meter;

    localparam int unsigned GC = 100;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          cont;
    logic          sig;
    logic [CW-1:0] count;
    logic          valid;
    logic          busy;
    logic          ovf;

    logic sq_en  = 1'b0;
    logic sq     = 1'b0;
    logic sig_lvl = 1'b0;
    int   per    = 10;
    int   ph     = 0;

    int nvec = 0;
    int nerr = 0;

    assign sig = sq_en ? sq : sig_lvl;

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(7), .CNT_W(CW)) dut (
        .CLK_IN(clk),
        .RST   (rst_n),
        .SIG_IN(sig),
        .START (start),
        .CONT  (cont),
        .COUNT (count),
        .VALID (valid),
        .BUSY  (busy),
        .OVF   (ovf)
    );

    always #5 clk = ~clk;

    // Square wave of period 'per' clocks: exactly one rise every 'per' cycles.
    always begin
        @(posedge clk);
        #1;
        ph = (ph + 1 >= per) ? 0 : ph + 1;
        sq = (ph < per / 2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!valid && lat < 150);
    endtask

    task automatic run_window(output int lat);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(lat);
    endtask

    initial begin
        int lat;
        int nv;
        int busy_low;
        int total;
        int bad_cnt;

        rst_n   = 1'b0;
        start   = 1'b0;
        cont    = 1'b0;
        sig_lvl = 1'b1;
        repeat (3) step();
        check("rst count", count, 0);
        check("rst valid", valid, 0);
        check("rst ovf",   ovf,   0);
        check("rst busy",  busy,  1);

        // SIG_IN high through reset, START pulsed during WARM
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("warm busy1", busy, 1);
        step();
        check("warm busy2", busy, 1);
        step();
        check("idle busy", busy, 0);
        step();
        check("start ignored in warm", busy, 0);
        run_window(lat);
        check("const high latency", lat, 100);
        check("const high count", count, 0);
        check("const high ovf", ovf, 0);

        // period 10 -> 10 edges
        sig_lvl = 1'b0;
        per     = 10;
        sq_en   = 1'b1;
        repeat (40) step();
        run_window(lat);
        check("p10 latency", lat, 100);
        check("p10 count", count, 10);
        check("p10 ovf", ovf, 0);
        step();
        check("p10 busy after valid", busy, 0);
        check("p10 valid one cycle", valid, 0);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid) nv++;
        end
        check("p10 single strobe", nv, 0);
        check("p10 count hold", count, 10);

        // period 4 -> 25 edges saturate a 4-bit counter
        per = 4;
        repeat (40) step();
        run_window(lat);
        check("p4 count", count, 15);
        check("p4 ovf", ovf, 1);

        // reset mid-window
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        check("midwin busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort count", count, 0);
        check("abort ovf", ovf, 0);
        check("abort valid", valid, 0);
        check("abort busy", busy, 1);
        step();
        rst_n = 1'b1;
        step();
        check("rewarm busy1", busy, 1);
        step();
        check("rewarm busy2", busy, 1);
        step();
        check("rewarm idle", busy, 0);
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (valid) nv++;
        end
        check("abort no valid", nv, 0);

        // period 20 -> 5 edges, overflow cleared
        per = 20;
        repeat (40) step();
        run_window(lat);
        check("p20 count", count, 5);
        check("p20 ovf", ovf, 0);
        repeat (5) step();
        check("p20 count hold", count, 5);

        // continuous mode, period 8
        per = 8;
        repeat (40) step();
        cont = 1'b1;
        step();
        nv       = 0;
        busy_low = 0;
        total    = 0;
        bad_cnt  = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (!busy) busy_low++;
            if (valid) begin
                nv++;
                check("cont strobe position", i, 100 * nv);
                total += int'(count);
                if (count != 12 && count != 13) bad_cnt++;
            end
        end
        check("cont strobes", nv, 3);
        check("cont never idle", busy_low, 0);
        check("cont counts 12/13", bad_cnt, 0);
        check("cont total 37/38", (total == 37 || total == 38), 1);
        cont = 1'b0;
        wait_valid(lat);
        check("cont last window", lat, 100);
        step();
        check("cont exit busy", busy, 0);

        // single rise landing on the last GATE cycle
        sq_en   = 1'b0;
        sig_lvl = 1'b0;
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (97) step();
        sig_lvl = 1'b1;
        repeat (3) step();
        check("last-cycle valid", valid, 1);
        check("last-cycle count", count, 1);

        // same rise one cycle later is discarded
        sig_lvl = 1'b0;
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (98) step();
        sig_lvl = 1'b1;
        repeat (2) step();
        check("late valid", valid, 1);
        check("late count", count, 0);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (valid) nv++;
        end
        check("late no extra strobe", nv, 0);
        check("late count hold", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
